adc733_frame_asm: RTL and testbench

// - Downstream of the adc733 serial core: collects one 16-bit word per channel per sync frame, assembles NUM_CH-word frames.
// - Double-buffers frames in two banks (ping-pong); streams them out on a valid/ready word interface.
// - Flags dropped frames, overflow and channel-sequence errors.
// - Runs on the serial core's clock, so all inputs are synchronous to clk.

---
 rtl/adc733_frame_asm_pkg.sv | 23 ++
 rtl/adc733_frame_asm_bank.sv | 46 ++++
 rtl/adc733_frame_asm.sv | 198 +++++++++++++++++++
 tb/tb_adc733_frame_asm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc733_frame_asm_pkg.sv
// Shared parameters, state types and helpers for the adc733 frame assembler.
package adc733_frame_asm_pkg;
    localparam int unsigned DEF_NUM_CH = 6;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned CH_W       = 3;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_FILL    = 2'd1,
        W_DISCARD = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rd_state_t;

    // Next slot index, wrapping at n.
    function automatic logic [CH_W-1:0] slot_inc(input logic [CH_W-1:0] s, input int unsigned n);
        return ((32'(s) + 32'd1) >= n) ? '0 : s + CH_W'(1);
    endfunction
endpackage

// File: rtl/adc733_frame_asm_bank.sv
// Ping-pong frame storage: 2 x NUM_CH words, one write port, registered read port, full flags.
module adc733_frame_asm_bank
    import adc733_frame_asm_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [CH_W-1:0]   wr_slot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              set_full,
    input  logic              re,
    input  logic              rd_bank,
    input  logic [CH_W-1:0]   rd_slot,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_full,
    input  logic              clr_bank,
    output logic [1:0]        full
);
    logic [DATA_W-1:0] mem [2][NUM_CH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_slot] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_bank][rd_slot];
        end
    end

    // Set is written last so it wins if both ever address the same bank.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            full <= '0;
        end else begin
            if (clr_full) full[clr_bank] <= 1'b0;
            if (set_full) full[wr_bank]  <= 1'b1;
        end
    end
endmodule

// File: rtl/adc733_frame_asm.sv
// Assembles per-channel adc733 words into NUM_CH-word frames, double-buffers them and
// streams them out on a valid/ready word interface with drop/overflow/sequence reporting.
module adc733_frame_asm
    import adc733_frame_asm_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              operation_mode,
    input  logic              sync,
    input  logic              rd_en,
    input  logic [2:0]        channel,
    input  logic [DATA_W-1:0] captured_data,
    output logic [DATA_W-1:0] m_data,
    output logic [2:0]        m_chan,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow,
    output logic              seq_err,
    input  logic              clr_flags
);
    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

    wr_state_t       w_state, w_next;
    rd_state_t       r_state, r_next;
    logic            wr_stb, accept;
    logic            wr_bank, wr_bank_next;
    logic [CH_W-1:0] slot, slot_next;
    logic [1:0]      full;
    logic            we, set_full, frame_inc, drop_inc, ovf_set, seq_set;
    logic            rd_bank, rd_bank_next, re, clr_full, rd_addr_bank;
    logic [CH_W-1:0] rd_addr_slot, chan_next;
    logic            valid_next;

    adc733_frame_asm_bank #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk      (clk),
        .rst_l    (rst_l),
        .we       (we),
        .wr_bank  (wr_bank),
        .wr_slot  (slot),
        .wr_data  (captured_data),
        .set_full (set_full),
        .re       (re),
        .rd_bank  (rd_addr_bank),
        .rd_slot  (rd_addr_slot),
        .rd_data  (m_data),
        .clr_full (clr_full),
        .clr_bank (rd_bank),
        .full     (full)
    );

    always_comb begin
        w_next       = w_state;
        slot_next    = slot;
        wr_bank_next = wr_bank;
        we           = 1'b0;
        set_full     = 1'b0;
        frame_inc    = 1'b0;
        drop_inc     = 1'b0;
        ovf_set      = 1'b0;
        if (!operation_mode) begin
            w_next    = W_IDLE;
            slot_next = '0;
            drop_inc  = (w_state == W_FILL) && (slot != '0);
        end else begin
            unique case (w_state)
                W_IDLE: if (sync) begin
                    slot_next = '0;
                    if (!full[wr_bank]) begin
                        w_next = W_FILL;
                    end else if (!full[~wr_bank]) begin
                        wr_bank_next = ~wr_bank;
                        w_next       = W_FILL;
                    end else begin
                        w_next   = W_DISCARD;
                        drop_inc = 1'b1;
                    end
                end
                W_FILL: if (sync) begin
                    drop_inc  = (slot != '0);
                    slot_next = '0;
                end else if (wr_stb) begin
                    we = 1'b1;
                    if (slot == LAST) begin
                        set_full  = 1'b1;
                        frame_inc = 1'b1;
                        slot_next = '0;
                        if (!full[~wr_bank]) begin
                            wr_bank_next = ~wr_bank;
                        end else begin
                            w_next  = W_DISCARD;
                            ovf_set = 1'b1;
                        end
                    end else begin
                        slot_next = slot + CH_W'(1);
                    end
                end
                W_DISCARD: if (sync) begin
                    if (!full[~wr_bank]) begin
                        wr_bank_next = ~wr_bank;
                        slot_next    = '0;
                        w_next       = W_FILL;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    // Words are only taken while the writer stays in W_FILL; the tag is checked against
    // slot_next so a completion strobe in the same cycle is already accounted for.
    assign accept  = rd_en && !sync && (w_state == W_FILL) && (w_next == W_FILL);
    assign seq_set = accept && (channel != slot_inc(slot_next, NUM_CH));

    always_comb begin
        r_next       = r_state;
        rd_bank_next = rd_bank;
        re           = 1'b0;
        clr_full     = 1'b0;
        rd_addr_bank = rd_bank;
        rd_addr_slot = '0;
        valid_next   = m_valid;
        chan_next    = m_chan;
        unique case (r_state)
            R_IDLE: if (full[rd_bank]) begin
                re         = 1'b1;
                r_next     = R_SEND;
                valid_next = 1'b1;
                chan_next  = '0;
            end
            R_SEND: if (m_ready) begin
                if (m_chan == LAST) begin
                    clr_full     = 1'b1;
                    rd_bank_next = ~rd_bank;
                    chan_next    = '0;
                    if (full[~rd_bank]) begin
                        re           = 1'b1;
                        rd_addr_bank = ~rd_bank;
                    end else begin
                        r_next     = R_IDLE;
                        valid_next = 1'b0;
                    end
                end else begin
                    re           = 1'b1;
                    rd_addr_slot = m_chan + CH_W'(1);
                    chan_next    = m_chan + CH_W'(1);
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            wr_stb    <= 1'b0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            slot      <= '0;
            m_valid   <= 1'b0;
            m_chan    <= '0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            w_state   <= w_next;
            r_state   <= r_next;
            wr_stb    <= accept;
            wr_bank   <= wr_bank_next;
            rd_bank   <= rd_bank_next;
            slot      <= slot_next;
            m_valid   <= valid_next;
            m_chan    <= chan_next;
            m_first   <= valid_next && (chan_next == '0);
            m_last    <= valid_next && (chan_next == LAST);
            if (frame_inc) frame_cnt <= frame_cnt + CNT_W'(1);
            if (drop_inc)  drop_cnt  <= drop_cnt + CNT_W'(1);
            overflow  <= ovf_set || (overflow && !clr_flags);
            seq_err   <= seq_set || (seq_err && !clr_flags);
        end
    end
endmodule

// File: tb/tb_adc733_frame_asm.sv
// Directed bench for adc733_frame_asm: scoreboard of expected output words plus literal checks.
module tb_adc733_frame_asm;
    localparam int unsigned NUM_CH = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              operation_mode = 1'b0;
    logic              sync = 1'b0;
    logic              rd_en = 1'b0;
    logic [2:0]        channel = '0;
    logic [DATA_W-1:0] captured_data = '0;
    logic              m_ready = 1'b0;
    logic              clr_flags = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        m_chan;
    logic              m_valid, m_first, m_last, overflow, seq_err;
    logic [CNT_W-1:0]  frame_cnt, drop_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        chan;
    } word_t;
    word_t sb[$];

    always #5 clk = ~clk;

    adc733_frame_asm #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .operation_mode (operation_mode),
        .sync           (sync),
        .rd_en          (rd_en),
        .channel        (channel),
        .captured_data  (captured_data),
        .m_data         (m_data),
        .m_chan         (m_chan),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_first        (m_first),
        .m_last         (m_last),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow),
        .seq_err        (seq_err),
        .clr_flags      (clr_flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Every valid output word must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_l && m_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL extra_word: got data 0x%0h chan %0d expected no word at %0t",
                         m_data, m_chan, $time);
            end else begin
                chk("m_data",  32'(m_data),  32'(sb[0].data));
                chk("m_chan",  32'(m_chan),  32'(sb[0].chan));
                chk("m_first", 32'(m_first), 32'(sb[0].chan == 3'd0));
                chk("m_last",  32'(m_last),  32'(sb[0].chan == 3'(NUM_CH - 1)));
                if (m_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] data, input logic [2:0] tag, input int gap);
        rd_en   = 1'b1;
        channel = tag;
        tick();
        rd_en         = 1'b0;
        captured_data = data;
        tick();
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] base, input int nwords, input int bad_idx,
                              input logic [2:0] bad_tag, input bit deliver);
        if (deliver) begin
            for (int k = 0; k < nwords; k++) sb.push_back({base + DATA_W'(k), 3'(k)});
            exp_frames++;
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        for (int k = 0; k < nwords; k++)
            send_word(base + DATA_W'(k), (k == bad_idx) ? bad_tag : 3'((k + 1) % NUM_CH), 2);
    endtask

    task automatic drain(input bit toggle);
        int cyc = 0;
        while ((sb.size() != 0 || m_valid) && cyc < 300) begin
            if (toggle) m_ready = ~m_ready;
            tick();
            cyc++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_m_first",   32'(m_first),   32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_seq_err",   32'(seq_err),   32'd0);
        rst_l          = 1'b1;
        operation_mode = 1'b1;
        m_ready        = 1'b1;
        repeat (2) tick();

        // Basic frame: latency 2 from last write strobe, one word per cycle.
        for (int k = 0; k < NUM_CH; k++) sb.push_back({16'h1000 + DATA_W'(k), 3'(k)});
        exp_frames++;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        for (int k = 0; k < NUM_CH - 1; k++) send_word(16'h1000 + DATA_W'(k), 3'(k + 1), 2);
        send_word(16'h1005, 3'd0, 0);
        chk("lat_not_yet", 32'(m_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_first", 32'(m_first), 32'd1);
        for (int i = 0; i < NUM_CH; i++) begin
            chk("tput_valid", 32'(m_valid), 32'd1);
            chk("tput_data",  32'(m_data),  32'h1000 + 32'(i));
            tick();
        end
        chk("tput_done", 32'(m_valid), 32'd0);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        drain(1'b0);

        // Output stalled every other cycle.
        m_ready = 1'b0;
        send_frame(16'h1100, NUM_CH, -1, 3'd0, 1'b1);
        drain(1'b1);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Three frames with sink stalled: two buffered, third lost.
        m_ready = 1'b0;
        send_frame(16'h2000, NUM_CH, -1, 3'd0, 1'b1);
        send_frame(16'h2100, NUM_CH, -1, 3'd0, 1'b1);
        send_frame(16'h2200, NUM_CH, -1, 3'd0, 1'b0);
        exp_drops++;
        chk("t3_overflow",  32'(overflow),  32'd1);
        chk("t3_drop_cnt",  32'(drop_cnt),  32'd1);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd4);
        m_ready = 1'b1;
        drain(1'b0);

        // Partial frame cut short by sync, then a full frame.
        send_frame(16'h3000, 3, -1, 3'd0, 1'b0);
        send_frame(16'h4000, NUM_CH, -1, 3'd0, 1'b1);
        exp_drops++;
        drain(1'b0);
        chk("t4_drop_cnt",  32'(drop_cnt),  32'd2);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        chk("t4_seq_err",   32'(seq_err),   32'd0);

        // Wrong tag on the second word.
        send_frame(16'h5000, NUM_CH, 1, 3'd3, 1'b1);
        chk("t5_seq_err", 32'(seq_err), 32'd1);
        drain(1'b0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t5_seq_clr", 32'(seq_err),  32'd0);
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

        // Reset during output.
        m_ready = 1'b0;
        send_frame(16'h6000, NUM_CH, -1, 3'd0, 1'b1);
        for (int i = 0; i < 50 && !m_valid; i++) tick();
        chk("t6_valid_pre", 32'(m_valid), 32'd1);
        #2 rst_l = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(m_valid), 32'd0);
        sb.delete();
        exp_frames = 0;
        exp_drops  = 0;
        tick();
        rst_l   = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("t6_frame_cnt0", 32'(frame_cnt), 32'd0);
        chk("t6_drop_cnt0",  32'(drop_cnt),  32'd0);
        send_frame(16'h7000, NUM_CH, -1, 3'd0, 1'b1);
        drain(1'b0);
        chk("t6_frame_cnt1", 32'(frame_cnt), 32'd1);
        chk("t6_overflow",   32'(overflow),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
